seq_chunk_feeder: RTL

- Supplier end of the S/T sequence request interface of the PE-array controller.
- Accepts a serial stream of 2-bit nucleotide codes from the host/loader side and packs them into PE_ARRAY_SIZE-element chunks.
- Presents a chunk with per-element valid bits and a last flag each time the controller pulses its request.
- One instance feeds S and a second instance feeds T.

---
 rtl/seq_chunk_feeder_pkg.sv | 15 +
 rtl/seq_chunk_feeder_if.sv | 25 ++
 rtl/seq_chunk_feeder_lane.sv | 34 +++
 rtl/seq_chunk_feeder.sv | 71 +++++++
 4 files changed

// File: rtl/seq_chunk_feeder_pkg.sv
// Shared constants for the S/T sequence feeders: chunk size, nucleotide codes
// and the 2-bit-per-element packing used on sIn/tIn.
package seq_chunk_feeder_pkg;

    localparam int PE_Array_size = 8;
    localparam int BASE_W        = 2;

    typedef logic [BASE_W-1:0] base_t;

    localparam base_t BASE_A = 2'd0;
    localparam base_t BASE_C = 2'd1;
    localparam base_t BASE_G = 2'd2;
    localparam base_t BASE_T = 2'd3;

endpackage

// File: rtl/seq_chunk_feeder_if.sv
// Host base stream in, controller chunk request/response out; element i of
// seqOut sits at bits [2i+1:2i].
interface seq_chunk_feeder_if #(
    parameter int PE_ARRAY_SIZE = seq_chunk_feeder_pkg::PE_Array_size
);
    logic                                                        base_valid;
    logic                                                        base_ready;
    seq_chunk_feeder_pkg::base_t                                 base_data;
    logic                                                        base_last;
    logic                                                        request;
    logic [PE_ARRAY_SIZE-1:0][seq_chunk_feeder_pkg::BASE_W-1:0]  seqOut;
    logic [PE_ARRAY_SIZE-1:0]                                    seqValid;
    logic                                                        seqLast;
    logic                                                        pending;

    modport master (
        output base_valid, base_data, base_last, request,
        input  base_ready, seqOut, seqValid, seqLast, pending
    );

    modport slave (
        input  base_valid, base_data, base_last, request,
        output base_ready, seqOut, seqValid, seqLast, pending
    );
endinterface

// File: rtl/seq_chunk_feeder_lane.sv
// One chunk element: a fill slot written by the host side and an output slot
// that takes the fill slot on a serve edge.
module seq_chunk_feeder_lane
    import seq_chunk_feeder_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  wrEn,
    input  base_t wrData,
    input  logic  serve,
    output base_t laneOut,
    output logic  laneVld
);
    base_t fillData;
    logic  fillVld;

    // serve and wrEn are exclusive: a base is never accepted while a chunk is complete
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fillData <= '0;
            fillVld  <= 1'b0;
            laneOut  <= '0;
            laneVld  <= 1'b0;
        end else if (serve) begin
            laneOut  <= fillData;
            laneVld  <= fillVld;
            fillData <= '0;
            fillVld  <= 1'b0;
        end else if (wrEn) begin
            fillData <= wrData;
            fillVld  <= 1'b1;
        end
    end
endmodule

// File: rtl/seq_chunk_feeder.sv
// Packs a serial 2-bit base stream into PE_ARRAY_SIZE-element chunks and hands
// one chunk to the PE-array controller per request (one instance each for S and T).
module seq_chunk_feeder
    import seq_chunk_feeder_pkg::*;
#(
    parameter int PE_ARRAY_SIZE = PE_Array_size,
    parameter int CNT_W         = 4
) (
    input logic               clk,
    input logic               rst_n,
    seq_chunk_feeder_if.slave bus
);
    logic [CNT_W-1:0]                     fillCnt;
    logic                                 fillDone;
    logic                                 lastSeen;
    logic                                 pendingQ;
    logic                                 seqLastQ;
    logic                                 accept;
    logic                                 serve;
    logic [PE_ARRAY_SIZE-1:0][BASE_W-1:0] seqOutW;
    logic [PE_ARRAY_SIZE-1:0]             seqValidW;

    assign bus.base_ready = !fillDone;
    assign accept         = bus.base_valid && !fillDone;
    assign serve          = (bus.request || pendingQ) && fillDone;

    genvar g;
    generate
        for (g = 0; g < PE_ARRAY_SIZE; g++) begin : gLane
            seq_chunk_feeder_lane uLane (
                .clk     (clk),
                .rst_n   (rst_n),
                .wrEn    (accept && (fillCnt == CNT_W'(g))),
                .wrData  (bus.base_data),
                .serve   (serve),
                .laneOut (seqOutW[g]),
                .laneVld (seqValidW[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fillCnt  <= '0;
            fillDone <= 1'b0;
            lastSeen <= 1'b0;
            pendingQ <= 1'b0;
            seqLastQ <= 1'b0;
        end else if (serve) begin
            seqLastQ <= lastSeen;
            fillCnt  <= '0;
            fillDone <= 1'b0;
            lastSeen <= 1'b0;
            pendingQ <= 1'b0;
        end else begin
            // a request with no complete chunk waits; further requests fold into it
            if (bus.request)
                pendingQ <= 1'b1;
            if (accept) begin
                fillCnt  <= fillCnt + 1'b1;
                lastSeen <= bus.base_last;
                fillDone <= bus.base_last || (fillCnt == CNT_W'(PE_ARRAY_SIZE - 1));
            end
        end
    end

    assign bus.seqOut   = seqOutW;
    assign bus.seqValid = seqValidW;
    assign bus.seqLast  = seqLastQ;
    assign bus.pending  = pendingQ;
endmodule
